// File: rtl/issue_exec_stage_muldiv.sv
// issue_exec_stage_muldiv: multi-cycle integer multiplier stage (MUL/MULH/MULHSU/MULHU).
// The multiplier retires BPC bits per BUSY cycle on operand magnitudes; the sign is applied at the end.
// Optional feature: define MULDIV_EARLY_OUT_EN to finish as soon as the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | no op held; ready to accept
// BUSY  | shift-add iterations in progress
// DONE  | result presented on outputs until consumed
module issue_exec_stage_muldiv #(
  parameter int WIDTH   = 64,
  parameter int BPC     = 2,
  parameter int ROBsize = 16,
  parameter int CMDW    = 10,
  localparam int TAGW   = $clog2(ROBsize + 1)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] reservationStationVal1_i,
  input  logic [WIDTH-1:0] reservationStationVal2_i,
  input  logic [CMDW-1:0]  reservationStationCommands_i,
  input  logic [TAGW-1:0]  reservationStationTag_i,
  input  logic             readyRS_i,
  output logic             stallRS_o,
  input  logic             canGo_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] executeVal_o,
  output logic [CMDW-1:0]  executeCommands_o,
  output logic [TAGW-1:0]  executeTag_o,
  output logic [3:0]       executeFlags_o,
  output logic             valid_o
);

  localparam int N    = WIDTH / BPC;
  localparam int CNTW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [CMDW-1:0]      cmd_q, cmd_d;
  logic [TAGW-1:0]      tag_q, tag_d;
  logic [WIDTH-1:0]     res_q, res_d;

  logic [1:0]           op_in;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc_step, prod;
  logic [WIDTH-1:0]     mplier_rest;
  logic                 last_step;
  logic                 accept;

  // Operand sign handling: MULH treats both signed, MULHSU only A; MUL/MULHU are unsigned
  always_comb begin
    op_in = reservationStationCommands_i[1:0];
    a_neg = ((op_in == 2'b01) || (op_in == 2'b10)) && reservationStationVal1_i[WIDTH-1];
    b_neg = (op_in == 2'b01) && reservationStationVal2_i[WIDTH-1];
    // The most-negative value negates to 2^(WIDTH-1), which still fits as an unsigned magnitude
    a_mag = a_neg ? ({WIDTH{1'b0}} - reservationStationVal1_i) : reservationStationVal1_i;
    b_mag = b_neg ? ({WIDTH{1'b0}} - reservationStationVal2_i) : reservationStationVal2_i;
  end

  // One radix-2^BPC step: add multiplicand times the low multiplier digit
  always_comb begin
    acc_step    = acc_q + mcand_q * {{(2*WIDTH-BPC){1'b0}}, mplier_q[BPC-1:0]};
    prod        = neg_q ? ({(2*WIDTH){1'b0}} - acc_step) : acc_step;
    mplier_rest = mplier_q >> BPC;
`ifdef MULDIV_EARLY_OUT_EN
    last_step   = (cnt_q == '0) || (mplier_rest == '0);
`else
    last_step   = (cnt_q == '0);
`endif
  end

  // Handshake: stall while in reset, flushing, busy, or holding an unconsumed result
  always_comb begin
    stallRS_o = ~reset_n_i | flush_i |
                ~((state_q == S_IDLE) | ((state_q == S_DONE) & canGo_i));
    accept    = readyRS_i & ~stallRS_o;
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cmd_d    = cmd_q;
    tag_d    = tag_q;
    res_d    = res_q;
    unique case (state_q)
      S_BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << BPC;
        mplier_d = mplier_rest;
        cnt_d    = cnt_q - CNTW'(1);
        if (last_step) begin
          state_d = S_DONE;
          res_d   = (cmd_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end
      end
      S_DONE: begin
        if (canGo_i) state_d = S_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      state_d  = S_BUSY;
      cnt_d    = CNTW'(N - 1);
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
      neg_d    = a_neg ^ b_neg;
      cmd_d    = reservationStationCommands_i;
      tag_d    = reservationStationTag_i;
    end
    if (flush_i) state_d = S_IDLE;
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cmd_q    <= '0;
      tag_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cmd_q    <= cmd_d;
      tag_q    <= tag_d;
      res_q    <= res_d;
    end
  end

  // Result outputs are only driven while DONE; command/tag always show the last capture
  always_comb begin
    valid_o           = (state_q == S_DONE);
    executeVal_o      = valid_o ? res_q : '0;
    executeFlags_o    = {3'b000, valid_o & (res_q == '0)};
    executeCommands_o = cmd_q;
    executeTag_o      = tag_q;
  end

endmodule
